mem_dump_reader: RTL and testbench
==================================

Name: mem_dump_reader

Overview:
- Debug readback engine for the multicycle MIPS unified RAM.
- On command, reads a contiguous block of words from RAM and streams them out MSB-first as bytes over a valid/ready interface.
- Lets the bench or host recover program and data contents (e.g. results at word 512+) after the CPU halts.
- Sits beside the datapath RAM on a dedicated synchronous read port; `busy` is used to hold the CPU.

Parameters:
- ADDR_W, 10, word-address width of the RAM; addresses wrap modulo 2^ADDR_W
- DATA_W, 32, RAM word width; fixed at 32 (4 bytes per word)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-low reset
- start  in  1  command strobe; sampled only in IDLE
- base_addr  in  ADDR_W  first word address, captured on accepted start
- word_count  in  ADDR_W+1  number of words to dump, captured on accepted start; 0 is legal
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the dump is complete
- mem_rd_en  out  1  RAM read strobe
- mem_addr  out  ADDR_W  RAM word address
- mem_rdata  in  DATA_W  RAM read data; valid the cycle after mem_rd_en (synchronous RAM)
- tx_data  out  8  stream byte
- tx_valid  out  1  stream byte valid
- tx_ready  in  1  sink ready; a byte transfers when tx_valid && tx_ready on a rising edge

Behaviour:
- Reset (rst==0 at an edge): state=IDLE. busy=0, done=0, mem_rd_en=0, mem_addr=0, tx_valid=0, tx_data=0. Internal address, remaining count, shift register and byte index are cleared.
- Reset mid-operation aborts at that edge. tx_valid drops even if a byte is pending; no done pulse is issued.
- FSM states: IDLE, RD_REQ, RD_WAIT, SEND, DONE.
- IDLE:
  - start=1 and word_count!=0 -> RD_REQ; captures base_addr and word_count.
  - start=1 and word_count==0 -> DONE.
  - start while not in IDLE is ignored and not queued.
- RD_REQ: one cycle. mem_rd_en=1, mem_addr=current address. Next state is RD_WAIT.
- RD_WAIT: one cycle. mem_rd_en=0. mem_rdata is loaded into the 32-bit shift register at the end of this cycle. Next state is SEND with byte index 0.
- SEND:
  - tx_valid=1 throughout.
  - tx_data = bits [31:24], [23:16], [15:8], [7:0] for byte index 0..3.
  - tx_data and tx_valid are held stable while tx_ready=0; no byte is ever dropped or duplicated.
  - On transfer of byte 3: address increments (wraps modulo 2^ADDR_W) and remaining count decrements.
  - After byte 3, remaining!=0 -> RD_REQ; otherwise -> DONE.
- DONE: done=1 for exactly one cycle, then -> IDLE. busy=1 during DONE.
- Latency:
  - start accepted at edge E; mem_rd_en high in the cycle after E.
  - First tx_valid appears 3 cycles after E.
  - With tx_ready held at 1, each word costs 6 cycles (RD_REQ, RD_WAIT, 4×SEND).
- mem_addr holds its last value when mem_rd_en=0.

Optional Feature:
- Macro: MEMDUMP_CHECKSUM_EN.
- Defined:
  - A 32-bit XOR accumulator is cleared on accepted start and XORs in each word as it is loaded in RD_WAIT.
  - After the last data word, state CSUM sends the accumulator as 4 bytes MSB-first, with the same handshake rules as SEND, then goes to DONE.
  - word_count==0 still goes straight to DONE with no checksum bytes.
- Undefined: no accumulator and no CSUM state; the stream carries data bytes only.

Test Plan:
- mem[527]=5; start, base=527, count=1, tx_ready=1 -> bytes 00 00 00 05; done pulse 7 cycles after start edge; busy low the cycle after done.
- mem[0]=20190200, mem[1]=00008020; base=0, count=2 -> bytes 20 19 02 00 00 00 80 20; mem_rd_en pulses with mem_addr 0 then 1.
- Same dump with tx_ready=0 for 3 cycles while byte 2 (02) is presented -> tx_data stays 02 and tx_valid stays 1; the stream is unchanged afterwards.
- base=1023, count=2, mem[1023]=DEADBEEF, mem[0]=20190200 -> bytes DE AD BE EF 20 19 02 00; second read at mem_addr 0.
- count=0 -> no tx_valid, no mem_rd_en; done one cycle after start. Separately, rst=0 during byte 5 of a 2-word dump -> next cycle tx_valid=0, busy=0, no done; a new start afterwards works.
- With MEMDUMP_CHECKSUM_EN, base=0, count=2 (values above) -> 8 data bytes then 20 19 82 20, then done.

Source files
------------

// File: rtl/mem_dump_reader.sv
// Debug readback engine: dumps a block of RAM words as an MSB-first byte stream.
// Optional `MEMDUMP_CHECKSUM_EN appends a 4-byte XOR checksum of the dumped words.
module mem_dump_reader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        SEND    = 3'd3,
`ifdef MEMDUMP_CHECKSUM_EN
        CSUM    = 3'd4,
`endif
        DONE    = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W + 1)'(1);

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W-1:0]   last_addr;
    logic [ADDR_W:0]     remaining;
    logic [DATA_W-1:0]   shreg;
    logic [1:0]          byte_idx;
    logic                xfer;
    logic                last_byte;
    logic                last_word;
`ifdef MEMDUMP_CHECKSUM_EN
    logic [DATA_W-1:0]   acc;
`endif

    assign xfer      = tx_valid && tx_ready;
    assign last_byte = xfer && (byte_idx == 2'd3);
    assign last_word = (remaining == REM_ONE);

    // State register.
    // NOTE: sequential state is written only with non-blocking assignments so every
    // flop samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    // NOTE: state_nxt gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (word_count != '0) ? RD_REQ : DONE;
                end
            end
            RD_REQ:  state_nxt = RD_WAIT;
            RD_WAIT: state_nxt = SEND;
            SEND: begin
                if (last_byte) begin
                    if (!last_word) begin
                        state_nxt = RD_REQ;
                    end else begin
`ifdef MEMDUMP_CHECKSUM_EN
                        state_nxt = CSUM;
`else
                        state_nxt = DONE;
`endif
                    end
                end
            end
`ifdef MEMDUMP_CHECKSUM_EN
            CSUM: begin
                if (last_byte) begin
                    state_nxt = DONE;
                end
            end
`endif
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers: address, remaining count, shift register, byte index.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr      <= '0;
            last_addr <= '0;
            remaining <= '0;
            shreg     <= '0;
            byte_idx  <= '0;
`ifdef MEMDUMP_CHECKSUM_EN
            acc       <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        addr      <= base_addr;
                        remaining <= word_count;
`ifdef MEMDUMP_CHECKSUM_EN
                        acc       <= '0;
`endif
                    end
                end
                RD_REQ: begin
                    // Remember the issued address so mem_addr holds between reads.
                    last_addr <= addr;
                end
                RD_WAIT: begin
                    shreg    <= mem_rdata;
                    byte_idx <= 2'd0;
`ifdef MEMDUMP_CHECKSUM_EN
                    acc      <= acc ^ mem_rdata;
`endif
                end
                SEND: begin
                    if (xfer) begin
                        shreg    <= shreg << 8;
                        byte_idx <= byte_idx + 2'd1;
                    end
                    if (last_byte) begin
                        addr      <= addr + ADDR_ONE;
                        remaining <= remaining - REM_ONE;
`ifdef MEMDUMP_CHECKSUM_EN
                        if (last_word) begin
                            shreg <= acc;
                        end
`endif
                    end
                end
`ifdef MEMDUMP_CHECKSUM_EN
                CSUM: begin
                    if (xfer) begin
                        shreg    <= shreg << 8;
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    // Output decode, purely from state and datapath registers.
    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE);
        mem_rd_en = (state == RD_REQ);
        mem_addr  = mem_rd_en ? addr : last_addr;
`ifdef MEMDUMP_CHECKSUM_EN
        tx_valid  = (state == SEND) || (state == CSUM);
`else
        tx_valid  = (state == SEND);
`endif
        tx_data   = tx_valid ? shreg[DATA_W-1 -: 8] : 8'h00;
    end

endmodule

// File: tb/tb_mem_dump_reader.sv
// Self-checking bench for mem_dump_reader: table-driven dumps plus reset-abort sequence.
// Honours MEMDUMP_CHECKSUM_EN by expecting the trailing checksum bytes.
module tb_mem_dump_reader;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   word_count;
    logic              busy;
    logic              done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;

    logic [31:0] mem [1024];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic [9:0]  base;
        logic [10:0] count;
        logic [31:0] words [3];
        logic [31:0] csum;
        int          stall_idx;
        int          stall_len;
        int          junk_cyc;
        int          exp_done;
    } vec_t;

    vec_t vecs [7];

    mem_dump_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM model: data appears the cycle after the read strobe.
    always_ff @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int k, input string name, input logic [9:0] base,
                           input logic [10:0] count, input logic [31:0] w0,
                           input logic [31:0] w1, input logic [31:0] w2,
                           input logic [31:0] csum, input int stall_idx,
                           input int stall_len, input int junk_cyc, input int exp_done);
        vecs[k].name      = name;
        vecs[k].base      = base;
        vecs[k].count     = count;
        vecs[k].words[0]  = w0;
        vecs[k].words[1]  = w1;
        vecs[k].words[2]  = w2;
        vecs[k].csum      = csum;
        vecs[k].stall_idx = stall_idx;
        vecs[k].stall_len = stall_len;
        vecs[k].junk_cyc  = junk_cyc;
        vecs[k].exp_done  = exp_done;
    endtask

    task automatic run_vec(input int k);
        logic [7:0] exp_q [$];
        logic [7:0] got_q [$];
        logic [9:0] rd_q  [$];
        logic [9:0] exp_addr;
        int cyc, done_cyc, n_done, first_valid, stalled, exp_done;
        logic [31:0] got_word;
        string nm;
        nm = vecs[k].name;

        for (int w = 0; w < int'(vecs[k].count); w++) begin
            for (int b = 0; b < 4; b++) begin
                exp_q.push_back(8'(vecs[k].words[w] >> (24 - 8 * b)));
            end
        end
        exp_done = vecs[k].exp_done;
`ifdef MEMDUMP_CHECKSUM_EN
        if (vecs[k].count != 0) begin
            for (int b = 0; b < 4; b++) begin
                exp_q.push_back(8'(vecs[k].csum >> (24 - 8 * b)));
            end
            exp_done = exp_done + 4;
        end
`endif

        start      = 1'b1;
        base_addr  = vecs[k].base;
        word_count = vecs[k].count;
        tx_ready   = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        cyc = 1; done_cyc = -1; n_done = 0; first_valid = -1; stalled = 0;
        check({nm, "_busy_after_start"}, 32'(busy), 32'd1);

        while (cyc <= 40) begin
            if (cyc == vecs[k].junk_cyc) begin
                start      = 1'b1;
                base_addr  = 10'd100;
                word_count = 11'd1;
            end else begin
                start      = 1'b0;
            end
            if (tx_valid && got_q.size() == vecs[k].stall_idx && stalled < vecs[k].stall_len) begin
                tx_ready = 1'b0;
                stalled++;
                check($sformatf("%s_stall%0d_data", nm, stalled), 32'(tx_data),
                      32'(exp_q[vecs[k].stall_idx]));
            end else begin
                tx_ready = 1'b1;
            end
            if (mem_rd_en) rd_q.push_back(mem_addr);
            if (tx_valid && first_valid < 0) first_valid = cyc;
            if (tx_valid && tx_ready) got_q.push_back(tx_data);
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (cyc == 2 && vecs[k].count != 0) begin
                check({nm, "_mem_addr_hold"}, 32'(mem_addr), 32'(vecs[k].base));
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                check({nm, "_busy_after_done"}, 32'(busy), 32'd0);
                break;
            end
            @(negedge clk);
            cyc++;
        end
        start      = 1'b0;
        word_count = '0;
        tx_ready   = 1'b1;

        check({nm, "_done_pulses"}, 32'(n_done), 32'd1);
        check({nm, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
        check({nm, "_first_valid"}, 32'(first_valid), (vecs[k].count != 0) ? 32'd3 : 32'hFFFF_FFFF);
        check({nm, "_byte_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            got_word = (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF;
            check($sformatf("%s_byte%0d", nm, i), got_word, 32'(exp_q[i]));
        end
        check({nm, "_read_count"}, 32'(rd_q.size()), 32'(vecs[k].count));
        for (int i = 0; i < int'(vecs[k].count) && i < rd_q.size(); i++) begin
            exp_addr = vecs[k].base + 10'(i);
            check($sformatf("%s_rd_addr%0d", nm, i), 32'(rd_q[i]), 32'(exp_addr));
        end
        @(negedge clk);
    endtask

    initial begin
        int n_bad;
        rst        = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        tx_ready   = 1'b1;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[527]  = 32'h0000_0005;
        mem[0]    = 32'h2019_0200;
        mem[1]    = 32'h0000_8020;
        mem[1023] = 32'hDEAD_BEEF;
        mem[512]  = 32'h1122_3344;
        mem[513]  = 32'hA5A5_A5A5;
        mem[514]  = 32'h0000_FFFF;

        //          name     base  cnt  w0            w1            w2            csum          stall  junk done
        set_vec(0, "r527",  527, 1, 32'h0000_0005, 32'h0,        32'h0,        32'h0000_0005, -1, 0, 0,  7);
        set_vec(1, "two",     0, 2, 32'h2019_0200, 32'h0000_8020, 32'h0,        32'h2019_8220, -1, 0, 0, 13);
        set_vec(2, "wrap", 1023, 2, 32'hDEAD_BEEF, 32'h2019_0200, 32'h0,        32'hFEB4_BCEF, -1, 0, 0, 13);
        set_vec(3, "zero",    5, 0, 32'h0,        32'h0,        32'h0,        32'h0,         -1, 0, 0,  1);
        set_vec(4, "three", 512, 3, 32'h1122_3344, 32'hA5A5_A5A5, 32'h0000_FFFF, 32'hB487_691E, -1, 0, 0, 19);
        set_vec(5, "stall",   0, 2, 32'h2019_0200, 32'h0000_8020, 32'h0,        32'h2019_8220,  2, 3, 0, 16);
        set_vec(6, "junk",  527, 1, 32'h0000_0005, 32'h0,        32'h0,        32'h0000_0005, -1, 0, 4,  7);

        repeat (3) @(negedge clk);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_done",      32'(done),      32'd0);
        check("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_mem_addr",  32'(mem_addr),  32'd0);
        check("rst_tx_valid",  32'(tx_valid),  32'd0);
        check("rst_tx_data",   32'(tx_data),   32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 7; k++) begin
            run_vec(k);
        end

        // Reset abort while the fifth byte of a two-word dump is presented.
        start      = 1'b1;
        base_addr  = 10'd0;
        word_count = 11'd2;
        tx_ready   = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        word_count = '0;
        repeat (8) @(negedge clk);
        check("abort_pre_valid", 32'(tx_valid), 32'd1);
        check("abort_pre_data",  32'(tx_data),  32'h00);
        rst = 1'b0;
        @(negedge clk);
        check("abort_tx_valid",  32'(tx_valid),  32'd0);
        check("abort_busy",      32'(busy),      32'd0);
        check("abort_done",      32'(done),      32'd0);
        check("abort_mem_rd_en", 32'(mem_rd_en), 32'd0);
        rst = 1'b1;
        n_bad = 0;
        repeat (15) begin
            @(negedge clk);
            if (done || tx_valid || busy) n_bad++;
        end
        check("abort_quiet_after", 32'(n_bad), 32'd0);

        run_vec(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
